cpu_register_file: RTL
======================

// Module: cpu_register_file
// PURPOSE
//  Parametrised CPU register file: NUM_GPR general registers (index 0 = accumulator,
//  1 = X, 2 = Y, higher = extra), one stack pointer with push/pop arithmetic, and a
//  status register with per-bit masked update. Sits between the decode/control unit
//  and the ALU; two combinational read ports feed the ALU operand muxes.
// PARAMETERS
//  DATA_W     8      width of every register, data bus and status word
//  NUM_GPR    3      number of general registers (min 3: A, X, Y)
//  SEL_W      3      select width; must satisfy 2**SEL_W > NUM_GPR
//  SP_RST     8'hFF  stack pointer reset value (DATA_W bits)
//  STATUS_RST 8'h00  status reset value (DATA_W bits)
// PORTS
//  clk_1          in   1        clock; all state updates on its rising edge
//  rst            in   1        reset, asynchronous, active-high
//  wr_en          in   1        write strobe for wr_sel/wr_data
//  wr_sel         in   SEL_W    0..NUM_GPR-1 = GPR, NUM_GPR = SP, others ignored
//  wr_data        in   DATA_W   write data
//  rd_sel_a       in   SEL_W    read port A select (same encoding as wr_sel)
//  rd_sel_b       in   SEL_W    read port B select
//  rd_data_a      out  DATA_W   read port A data (combinational)
//  rd_data_b      out  DATA_W   read port B data (combinational)
//  sp_inc         in   1        pop: SP <= SP + 1
//  sp_dec         in   1        push: SP <= SP - 1
//  sp_out         out  DATA_W   current SP (registered value)
//  sp_wrap        out  1        registered 1-cycle pulse: SP inc/dec wrapped
//  status_wr_mask in   DATA_W   per-bit write enable for status
//  status_in      in   DATA_W   new status bits
//  status_out     out  DATA_W   current status (registered value)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-sequence): all GPRs 0, SP = SP_RST,
//    status = STATUS_RST, sp_wrap 0. First update on first clk_1 edge after rst falls.
//  - GPR write: wr_en & wr_sel < NUM_GPR -> reg[wr_sel] <= wr_data, 1-cycle latency.
//  - SP priority per edge: (wr_en & wr_sel == NUM_GPR) > (sp_inc ^ sp_dec) > hold.
//    sp_inc & sp_dec together: SP holds, sp_wrap 0. A write overrides inc/dec, sp_wrap 0.
//  - SP arithmetic modulo 2**DATA_W; sp_wrap <= 1 on inc from all-ones or dec from 0,
//    else 0 next edge (pulse, not sticky).
//  - Status: status[i] <= status_wr_mask[i] ? status_in[i] : status[i], every edge,
//    independent of GPR/SP activity; mask 0 = hold.
//  - Read: rd_sel < NUM_GPR -> GPR; == NUM_GPR -> SP; out of range -> 0.
//  - wr_en with out-of-range wr_sel: no state change.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: if wr_en and wr_sel == rd_sel_x (in range), rd_data_x
//    returns wr_data in the same cycle (write-through forwarding; SP included).
//    SP inc/dec results are NOT forwarded.
//  Undefined: read ports always return stored values; written data visible after edge.
// TESTING
//  1 Reset: assert rst mid-run -> rd A/X/Y = 0, sp_out = 8'hFF, status_out = 0 at once.
//  2 Write A=8'h3C, X=8'h5A, then read A on port a, X on port b -> 8'h3C / 8'h5A;
//    same-cycle read of written reg: 8'h3C with REGFILE_BYPASS_EN, old value without.
//  3 SP: from 8'hFF, three sp_dec -> 8'hFC; write SP=8'h00 then sp_dec -> 8'hFF and
//    sp_wrap high exactly one cycle; sp_inc from 8'hFF -> 8'h00, sp_wrap pulse.
//  4 Simultaneous: sp_inc & sp_dec -> SP unchanged; wr SP=8'h40 with sp_inc -> 8'h40.
//  5 Status: status=0, mask 8'h81 in 8'hFF -> 8'h81; mask 8'h01 in 8'h00 -> 8'h80.
//  6 Out-of-range wr_sel=7 with wr_en -> no register, SP or status change; rd_sel=7 -> 0.

Source files
------------

// File: rtl/cpu_register_file.sv
// CPU register file: GPRs (A, X, Y, extra), stack pointer with push/pop, masked status.
// Optional REGFILE_BYPASS_EN forwards same-cycle writes to the read ports.
module cpu_register_file #(
   parameter int              DATA_W     = 8,
   parameter int              NUM_GPR    = 3,
   parameter int              SEL_W      = 3,
   parameter logic [DATA_W-1:0] SP_RST   = 8'hFF,
   parameter logic [DATA_W-1:0] STATUS_RST = 8'h00
) (
   input  logic              clk_1,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [SEL_W-1:0]  wr_sel,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [SEL_W-1:0]  rd_sel_a,
   input  logic [SEL_W-1:0]  rd_sel_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              sp_inc,
   input  logic              sp_dec,
   output logic [DATA_W-1:0] sp_out,
   output logic              sp_wrap,
   input  logic [DATA_W-1:0] status_wr_mask,
   input  logic [DATA_W-1:0] status_in,
   output logic [DATA_W-1:0] status_out
);

   localparam logic [SEL_W-1:0] SP_SEL = SEL_W'(NUM_GPR);

   logic [DATA_W-1:0] r_gpr [NUM_GPR];
   logic [DATA_W-1:0] r_sp;
   logic [DATA_W-1:0] r_status;
   logic              r_sp_wrap;
   logic              w_sp_wr;
   logic [DATA_W-1:0] w_rd_a;
   logic [DATA_W-1:0] w_rd_b;

   assign w_sp_wr = wr_en && (wr_sel == SP_SEL);

   always_ff @(posedge clk_1 or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_GPR; i++) r_gpr[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_GPR; i++)
            if (wr_en && (wr_sel == SEL_W'(i))) r_gpr[i] <= wr_data;
      end
   end

   // A direct SP write wins over push/pop; inc and dec together cancel.
   always_ff @(posedge clk_1 or posedge rst) begin
      if (rst) begin
         r_sp      <= SP_RST;
         r_sp_wrap <= 1'b0;
      end else if (w_sp_wr) begin
         r_sp      <= wr_data;
         r_sp_wrap <= 1'b0;
      end else if (sp_inc && !sp_dec) begin
         r_sp      <= r_sp + 1'b1;
         r_sp_wrap <= &r_sp;
      end else if (sp_dec && !sp_inc) begin
         r_sp      <= r_sp - 1'b1;
         r_sp_wrap <= ~|r_sp;
      end else begin
         r_sp_wrap <= 1'b0;
      end
   end

   always_ff @(posedge clk_1 or posedge rst) begin
      if (rst) r_status <= STATUS_RST;
      else     r_status <= (r_status & ~status_wr_mask) |
                           (status_in & status_wr_mask);
   end

   always_comb begin
      w_rd_a = '0;
      for (int i = 0; i < NUM_GPR; i++)
         if (rd_sel_a == SEL_W'(i)) w_rd_a = r_gpr[i];
      if (rd_sel_a == SP_SEL) w_rd_a = r_sp;
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wr_sel == rd_sel_a) && (wr_sel <= SP_SEL))
         w_rd_a = wr_data;
`endif
   end

   always_comb begin
      w_rd_b = '0;
      for (int i = 0; i < NUM_GPR; i++)
         if (rd_sel_b == SEL_W'(i)) w_rd_b = r_gpr[i];
      if (rd_sel_b == SP_SEL) w_rd_b = r_sp;
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wr_sel == rd_sel_b) && (wr_sel <= SP_SEL))
         w_rd_b = wr_data;
`endif
   end

   assign rd_data_a  = w_rd_a;
   assign rd_data_b  = w_rd_b;
   assign sp_out     = r_sp;
   assign sp_wrap    = r_sp_wrap;
   assign status_out = r_status;

endmodule
